// File: rtl/cpu_types_pkg.sv
// Shared CPU types plus the pipeline controller's state and control-word definitions.
package cpu_types_pkg;

  typedef logic [4:0]  regbits_t;
  typedef logic [31:0] word_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } pctrl_state_t;

  // One control word per pipeline case; a flushed latch keeps its enable high
  // because the flush overrides it inside the latch anyway.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_flush;
  } pctrl_out_t;

  localparam pctrl_out_t CTRL_FREEZE  = 9'b0_0000_0000;
  localparam pctrl_out_t CTRL_BRANCH  = 9'b1_1111_1100;
  localparam pctrl_out_t CTRL_LOADUSE = 9'b0_0111_0100;
  localparam pctrl_out_t CTRL_IMISS   = 9'b0_1111_1000;
  localparam pctrl_out_t CTRL_NORMAL  = 9'b1_1111_0000;

  localparam word_t STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs from the datapath and stage enables/flushes back to it.
interface pipeline_ctrl_if;
  import cpu_types_pkg::*;

  logic     ihit;
  logic     dhit;
  logic     mem_dren;
  logic     mem_dwen;
  logic     ex_memread;
  regbits_t ex_rd;
  regbits_t id_rs;
  regbits_t id_rt;
  logic     ex_pcsrc;
  logic     wb_halt;

  logic     pc_en;
  logic     ifid_en;
  logic     idex_en;
  logic     exmem_en;
  logic     memwb_en;
  logic     ifid_flush;
  logic     idex_flush;
  logic     exmem_flush;
  logic     memwb_flush;
  logic     halt;
  word_t    stall_cnt;

  // Datapath side: drives hazard information, receives control.
  modport master (
    output ihit, dhit, mem_dren, mem_dwen, ex_memread, ex_rd, id_rs, id_rt,
           ex_pcsrc, wb_halt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, halt, stall_cnt
  );

  // Controller side.
  modport slave (
    input  ihit, dhit, mem_dren, mem_dwen, ex_memread, ex_rd, id_rs, id_rt,
           ex_pcsrc, wb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, memwb_flush, halt, stall_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Pure combinational hazard detection: data-cache stall and load-use dependency.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     dhit,
  input  logic     mem_dren,
  input  logic     mem_dwen,
  input  logic     ex_memread,
  input  regbits_t ex_rd,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  output logic     dstall,
  output logic     loaduse
);

  // A MEM access still waiting on the data cache freezes the whole pipe.
  assign dstall  = (mem_dren | mem_dwen) & ~dhit;

  // Register 0 is hardwired, so a load into it never creates a dependency.
  assign loaduse = ex_memread & (ex_rd != '0) & ((ex_rd == id_rs) | (ex_rd == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: run/halt state, prioritised stall/flush control, stall counter.
module pipeline_ctrl
  import cpu_types_pkg::*;
(
  input  logic            CLK,
  input  logic            RST,
  pipeline_ctrl_if.slave  bus
);

  pctrl_state_t state_q, state_d;
  word_t        stall_cnt_q;
  pctrl_out_t   ctrl;
  logic         stall_cycle;
  logic         dstall, loaduse;

  hazard_detect u_hazard (
    .dhit       (bus.dhit),
    .mem_dren   (bus.mem_dren),
    .mem_dwen   (bus.mem_dwen),
    .ex_memread (bus.ex_memread),
    .ex_rd      (bus.ex_rd),
    .id_rs      (bus.id_rs),
    .id_rt      (bus.id_rt),
    .dstall     (dstall),
    .loaduse    (loaduse)
  );

  // Next state and control word; reset forces the RUN rules on the outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    ctrl        = CTRL_FREEZE;
    stall_cycle = 1'b0;
    if (state_q == RUN || RST) begin
      if (dstall) begin
        ctrl        = CTRL_FREEZE;
        stall_cycle = 1'b1;
      end else if (bus.ex_pcsrc) begin
        // A taken branch squashes the ID instruction, so any load-use bubble is moot.
        ctrl = CTRL_BRANCH;
      end else if (loaduse) begin
        ctrl        = CTRL_LOADUSE;
        stall_cycle = 1'b1;
      end else if (!bus.ihit) begin
        ctrl        = CTRL_IMISS;
        stall_cycle = 1'b1;
      end else begin
        ctrl = CTRL_NORMAL;
      end
      // The halt only retires once its MEM/WB slot is no longer frozen.
      if (bus.wb_halt && !dstall) state_d = HALTED;
    end
  end

  // State register; HALTED is left only through reset.
  always_ff @(posedge CLK) begin
    // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
    if (RST) state_q <= RUN;
    else     state_q <= state_d;
  end

  // Saturating count of cycles spent stalled in RUN.
  always_ff @(posedge CLK) begin
    if (RST)
      stall_cnt_q <= '0;
    else if (stall_cycle && stall_cnt_q != STALL_CNT_MAX)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign bus.pc_en       = ctrl.pc_en;
  assign bus.ifid_en     = ctrl.ifid_en;
  assign bus.idex_en     = ctrl.idex_en;
  assign bus.exmem_en    = ctrl.exmem_en;
  assign bus.memwb_en    = ctrl.memwb_en;
  assign bus.ifid_flush  = ctrl.ifid_flush;
  assign bus.idex_flush  = ctrl.idex_flush;
  assign bus.exmem_flush = ctrl.exmem_flush;
  assign bus.memwb_flush = ctrl.memwb_flush;
  assign bus.halt        = (state_q == HALTED);
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 CLK  in  1  system clock; all state updates on rising edge.
REQ-002 RST  in  1  synchronous, active-high reset.
REQ-003 ihit  in  1  instruction cache returned the fetch this cycle.
REQ-004 dhit  in  1  data cache completed the MEM-stage access this cycle.
REQ-005 mem_dren, mem_dwen  in  1 each  MEM-stage load/store request (EX/MEM latch outputs).
REQ-006 ex_memread  in  1  instruction in EX is a load.
REQ-007 ex_rd  in  5 (regbits_t)  EX-stage destination register.
REQ-008 id_rs, id_rt  in  5 (regbits_t)  ID-stage source registers.
REQ-009 ex_pcsrc  in  1  branch taken or jump resolved in EX this cycle.
REQ-010 wb_halt  in  1  halt instruction at MEM/WB latch output.
REQ-011 pc_en  out  1  PC register load enable.
REQ-012 ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables.
REQ-013 ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  latch clears; flush overrides en in the latch.
REQ-014 halt  out  1  registered, sticky processor-halted flag.
REQ-015 stall_cnt  out  32 (word_t)  saturating count of stalled cycles.

Function
REQ-016 Outputs are combinational from state and inputs, except halt and stall_cnt, which are registered.
REQ-017 States: RUN, HALTED; RUN->HALTED on wb_halt=1 while dstall=0; HALTED exits only on RST.
REQ-018 dstall = (mem_dren|mem_dwen) & ~dhit; loaduse = ex_memread & (ex_rd!=0) & (ex_rd==id_rs | ex_rd==id_rt).
REQ-019 Case priority in RUN, highest first: dstall, ex_pcsrc, loaduse, ~ihit, normal.
REQ-020 dstall: pc_en and all four en = 0, all flush = 0 (full freeze, no state lost).
REQ-021 ex_pcsrc: pc_en=1 (PC loads the target regardless of ihit), all en=1, ifid_flush=1, idex_flush=1, other flushes 0.
REQ-022 loaduse: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1 (one bubble per cycle while the hazard holds).
REQ-023 ~ihit: pc_en=0, ifid_flush=1, idex_en=exmem_en=memwb_en=1 (bubble inserted behind the fetch).
REQ-024 normal: pc_en and all en = 1, all flush = 0.
REQ-025 HALTED: pc_en and all en = 0, all flush = 0, halt=1.
REQ-026 halt is set on the clock edge that enters HALTED, i.e. one cycle after the qualifying wb_halt.
REQ-027 stall_cnt increments by 1 on each RUN cycle where dstall|loaduse|~ihit, saturating at 0xFFFFFFFF; it does not increment on ex_pcsrc-only cycles or in HALTED.
REQ-028 ex_pcsrc together with loaduse: the flush case wins and the load-use bubble is dropped, because the ID instruction is squashed.

Reset
REQ-029 On RST=1 at a clock edge: state=RUN, halt=0, stall_cnt=0.
REQ-030 While RST=1, combinational outputs follow RUN-state rules; RST mid-stall or in HALTED returns the block to RUN on the next edge.

Structure
REQ-031 The state enum pctrl_state_t (RUN, HALTED) is added to cpu_types_pkg; regbits_t and word_t come from cpu_types_pkg.
REQ-032 A combinational sub-module hazard_detect computes dstall and loaduse; pipeline_ctrl holds the state register, the counter and the priority mux.

Verification
REQ-033 mem_dren=1, dhit=0 for 3 cycles, then dhit=1 -> all en/pc_en=0 for 3 cycles, normal on the 4th; stall_cnt=3.
REQ-034 ex_memread=1, ex_rd=5, id_rt=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1; with ex_rd=0 -> normal.
REQ-035 ex_pcsrc=1 with loaduse and ihit=0 -> pc_en=1, ifid_flush=idex_flush=1; stall_cnt unchanged.
REQ-036 ex_pcsrc=1 with dstall -> full freeze, no flush; ex_pcsrc case applies on the cycle after dhit.
REQ-037 wb_halt=1 with dstall=0 -> halt=1 next edge, all en=0 thereafter; RST=1 one cycle -> halt=0, stall_cnt=0, RUN.
REQ-038 stall_cnt preloaded by forcing 0xFFFFFFFE, two stall cycles -> stall_cnt holds 0xFFFFFFFF.
